// File: rtl/line_fill_engine_pkg.sv
// Shared types for the cache line fill/write-back path.
// Word/line geometry, FSM encoding and line slot helpers.
package line_fill_engine_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_BITS = 2;
  localparam int LINE_SIZE   = WORD_SIZE * LINE_WORDS;
  localparam int TAG_BITS    = WORD_SIZE - OFFSET_BITS;

  typedef logic [WORD_SIZE-1:0]   word_t;
  typedef logic [LINE_SIZE-1:0]   line_t;
  typedef logic [TAG_BITS-1:0]    tag_t;
  typedef logic [OFFSET_BITS-1:0] beat_idx_t;

  localparam beat_idx_t BEAT_FIRST = '0;
  localparam beat_idx_t BEAT_LAST  =
    beat_idx_t'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2
  } lfe_state_e;

  typedef struct packed {
    logic  req;
    logic  we;
    word_t addr;
    word_t wdata;
  } mem_beat_t;

  // Slot 0 sits in the most significant word of the line.
  function automatic word_t line_get(
    input line_t     line,
    input beat_idx_t slot
  );
    int sh;
    sh = (LINE_WORDS - 1 - int'(slot)) * WORD_SIZE;
    return word_t'(line >> sh);
  endfunction

  function automatic line_t line_put(
    input line_t     line,
    input beat_idx_t slot,
    input word_t     w
  );
    int    sh;
    line_t mask;
    sh   = (LINE_WORDS - 1 - int'(slot)) * WORD_SIZE;
    mask = line_t'({WORD_SIZE{1'b1}}) << sh;
    return (line & ~mask) | (line_t'(w) << sh);
  endfunction

endpackage

// File: rtl/line_fill_engine.sv
// Line fill / write-back sequencer: splits 64-bit cache line
// transfers into four 16-bit beats on a single-word memory port.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   req_rd, req_rd_addr   line fill request (held until read_ack)
//   req_wr, req_wr_addr,  write-back request and victim line
//   req_wr_line           (held until write_ack)
//   line_out, read_ack    assembled line + one-cycle fill done pulse
//   write_ack             one-cycle write-back done pulse
//   busy                  engine not idle
//   m_req, m_we, m_addr,  registered memory beat request
//   m_wdata
//   m_rdata, m_ready      memory read data and beat completion
module line_fill_engine
  import line_fill_engine_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_rd,
  input  logic [15:0] req_rd_addr,
  input  logic        req_wr,
  input  logic [15:0] req_wr_addr,
  input  logic [63:0] req_wr_line,
  output logic [63:0] line_out,
  output logic        read_ack,
  output logic        write_ack,
  output logic        busy,
  output logic        m_req,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_ready
);

  lfe_state_e state_q, state_d;
  beat_idx_t  cnt_q, cnt_d, cnt_nx;
  logic       rd_pend_q, rd_pend_d;
  tag_t       rd_tag_q, rd_tag_d;
  tag_t       wr_tag_q, wr_tag_d;
  line_t      wr_line_q, wr_line_d;
  line_t      fill_q, fill_d;
  line_t      line_q, line_d;
  logic       rack_q, rack_d;
  logic       wack_q, wack_d;
  mem_beat_t  mb_q, mb_d;

  logic beat_done;
  logic beat_last;
  logic unused_offsets;

  // m_ready only counts while a beat is actually offered.
  assign beat_done = mb_q.req & m_ready;
  assign beat_last = (cnt_q == BEAT_LAST);
  assign cnt_nx    = cnt_q + 1'b1;

  assign unused_offsets = ^{req_rd_addr[OFFSET_BITS-1:0],
                            req_wr_addr[OFFSET_BITS-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= '0;
      wr_tag_q  <= '0;
      wr_line_q <= '0;
      fill_q    <= '0;
      line_q    <= '0;
      rack_q    <= 1'b0;
      wack_q    <= 1'b0;
      mb_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
      wr_tag_q  <= wr_tag_d;
      wr_line_q <= wr_line_d;
      fill_q    <= fill_d;
      line_q    <= line_d;
      rack_q    <= rack_d;
      wack_q    <= wack_d;
      mb_q      <= mb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_pend_d = rd_pend_q;
    rd_tag_d  = rd_tag_q;
    wr_tag_d  = wr_tag_q;
    wr_line_d = wr_line_q;
    fill_d    = fill_q;
    line_d    = line_q;
    rack_d    = 1'b0;
    wack_d    = 1'b0;
    mb_d      = mb_q;

    unique case (state_q)
      IDLE: begin
        if (req_wr) begin
          state_d    = WB;
          wr_tag_d   = req_wr_addr[WORD_SIZE-1:OFFSET_BITS];
          wr_line_d  = req_wr_line;
          rd_pend_d  = req_rd;
          rd_tag_d   = req_rd_addr[WORD_SIZE-1:OFFSET_BITS];
          cnt_d      = BEAT_FIRST;
          mb_d.req   = 1'b1;
          mb_d.we    = 1'b1;
          mb_d.addr  = {wr_tag_d, BEAT_FIRST};
          mb_d.wdata = line_get(req_wr_line, BEAT_FIRST);
        end else if (req_rd) begin
          state_d   = RD;
          rd_tag_d  = req_rd_addr[WORD_SIZE-1:OFFSET_BITS];
          cnt_d     = BEAT_FIRST;
          mb_d.req  = 1'b1;
          mb_d.we   = 1'b0;
          mb_d.addr = {rd_tag_d, BEAT_FIRST};
        end
      end

      WB: begin
        // A fill raised during write-back waits its turn.
        if (req_rd && !rd_pend_q) begin
          rd_pend_d = 1'b1;
          rd_tag_d  = req_rd_addr[WORD_SIZE-1:OFFSET_BITS];
        end
        if (beat_done) begin
          if (beat_last) begin
            wack_d = 1'b1;
            cnt_d  = BEAT_FIRST;
            if (rd_pend_d) begin
              state_d   = RD;
              rd_pend_d = 1'b0;
              mb_d.we   = 1'b0;
              mb_d.addr = {rd_tag_d, BEAT_FIRST};
            end else begin
              state_d  = IDLE;
              mb_d.req = 1'b0;
            end
          end else begin
            cnt_d      = cnt_nx;
            mb_d.addr  = {wr_tag_q, cnt_nx};
            mb_d.wdata = line_get(wr_line_q, cnt_nx);
          end
        end
      end

      RD: begin
        if (beat_done) begin
          fill_d = line_put(fill_q, cnt_q, m_rdata);
          if (beat_last) begin
            // Publish the whole line only once it is complete.
            line_d    = fill_d;
            rack_d    = 1'b1;
            state_d   = IDLE;
            cnt_d     = BEAT_FIRST;
            rd_pend_d = 1'b0;
            mb_d.req  = 1'b0;
          end else begin
            cnt_d     = cnt_nx;
            mb_d.addr = {rd_tag_q, cnt_nx};
          end
        end
      end

      default: begin
        state_d  = IDLE;
        mb_d.req = 1'b0;
      end
    endcase
  end

  assign line_out  = line_q;
  assign read_ack  = rack_q;
  assign write_ack = wack_q;
  assign busy      = (state_q != IDLE);
  assign m_req     = mb_q.req;
  assign m_we      = mb_q.we;
  assign m_addr    = mb_q.addr;
  assign m_wdata   = mb_q.wdata;

endmodule
